// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring
// divide, with sign fix-up, divide special cases and pipeline stall/kill control.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      dbgState
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} stateT;

   stateT           state;
   logic [5:0]      cnt;
   logic [2:0]      fn;
   logic            negQ;
   logic            negR;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   // Operand decode for the instruction currently presented in X
   logic            isDiv, aSigned, bSigned, aNeg, bNeg, divZero, divOvf, accept;
   logic [XLEN-1:0] absA, absB, specialRes;

   always_comb begin
      isDiv      = funct3[2];
      aSigned    = isDiv ? ~funct3[0] : (funct3[1:0] != 2'b11);
      bSigned    = isDiv ? ~funct3[0] : ~funct3[1];
      aNeg       = aSigned & op_a[XLEN-1];
      bNeg       = bSigned & op_b[XLEN-1];
      absA       = aNeg ? -op_a : op_a;
      absB       = bNeg ? -op_b : op_b;
      divZero    = isDiv & (op_b == '0);
      divOvf     = isDiv & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
      specialRes = '0;
      if (divZero)
         specialRes = funct3[1] ? op_a : '1;
      else
         specialRes = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      accept     = (state == IDLE) & start & ~kill;
   end

   // One iteration: multiply consumes lo LSB-first, divide feeds lo MSB into hi
   logic [XLEN:0]   mulSum, divShift;
   logic [XLEN-1:0] divDiff;
   logic            divGe;

   always_comb begin
      mulSum   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {XLEN{1'b0}})};
      divShift = {hi, lo[XLEN-1]};
      divGe    = divShift >= {1'b0, mcand};
      divDiff  = divShift[XLEN-1:0] - mcand;
   end

   logic [2*XLEN-1:0] prod, prodFix;
   logic [XLEN-1:0]   quoFix, remFix, fixRes;

   always_comb begin
      prod    = {hi, lo};
      prodFix = negQ ? -prod : prod;
      quoFix  = negQ ? -lo : lo;
      remFix  = negR ? -hi : hi;
      case (fn)
         3'b000:                 fixRes = prodFix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fixRes = prodFix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fixRes = quoFix;
         default:                fixRes = remFix;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         fn     <= '0;
         negQ   <= 1'b0;
         negR   <= 1'b0;
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  fn    <= funct3;
                  negQ  <= aNeg ^ bNeg;
                  negR  <= aNeg;
                  mcand <= absB;
                  hi    <= '0;
                  lo    <= absA;
                  cnt   <= '0;
                  if (divZero | divOvf) begin
                     result <= specialRes;
                     state  <= DONE;
                  end else begin
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  if (fn[2]) begin
                     hi <= divGe ? divDiff : divShift[XLEN-1:0];
                     lo <= {lo[XLEN-2:0], divGe};
                  end else begin
                     hi <= mulSum[XLEN:1];
                     lo <= {mulSum[0], lo[XLEN-1:1]};
                  end
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd31)
                     state <= FIX;
               end
            end
            FIX: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  result <= fixRes;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == CALC) | (state == FIX);
   assign done      = (state == DONE);
   assign stall_req = accept | busy;
   assign dbgState  = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: arithmetic results, latency, stall,
// divide special cases, kill, reset abort and ignored starts.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        stall_req, busy, done;
   logic [31:0] result;
   logic [1:0]  dbgState;

   int total = 0;
   int bad   = 0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .stall_req(stall_req), .busy(busy),
      .done(done), .result(result), .dbgState(dbgState)
   );

   always #5 clk = ~clk;

   // Called at a negedge: presents one instruction for one cycle, scrambles the
   // operand buses afterwards, and waits (bounded) for done.
   task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
      funct3 = f; op_a = a; op_b = b; start = 1'b1; kill = 1'b0;
      #1;
      stalls = stall_req ? 1 : 0;
      @(negedge clk);
      start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
      lat = 1;
      while (!done && lat < 100) begin
         if (stall_req) stalls++;
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
      res = result;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      logic [31:0] r; int lat, st;
      runOp(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, st);
      total++; if (r !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul: got %h want ffffffeb", r); end
      total++; if (lat !== 34) begin bad++; $display("FAIL mul_latency: got %0d want 34", lat); end
      total++; if (st !== 34) begin bad++; $display("FAIL mul_stall_cycles: got %0d want 34", st); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL mul_stall_in_done: got %b want 0", stall_req); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
      runOp(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, st);
      total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu: got %h want fffffffe", r); end
      @(negedge clk);
      runOp(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, st);
      total++; if (r !== 32'h00000000) begin bad++; $display("FAIL mulh: got %h want 00000000", r); end
      @(negedge clk);
      runOp(3'b010, 32'hFFFFFFFF, 32'd2, r, lat, st);
      total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu: got %h want ffffffff", r); end
      @(negedge clk);
      runOp(3'b000, 32'h00012345, 32'h00010000, r, lat, st);
      total++; if (r !== 32'h23450000) begin bad++; $display("FAIL mul_shift: got %h want 23450000", r); end
      @(negedge clk);
   endtask

   task automatic test_div();
      logic [31:0] r; int lat, st;
      runOp(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, st);
      total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg: got %h want fffffffd", r); end
      total++; if (lat !== 34) begin bad++; $display("FAIL div_latency: got %0d want 34", lat); end
      @(negedge clk);
      runOp(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, st);
      total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_neg: got %h want ffffffff", r); end
      @(negedge clk);
      runOp(3'b101, 32'd100, 32'd7, r, lat, st);
      total++; if (r !== 32'd14) begin bad++; $display("FAIL divu: got %h want 0000000e", r); end
      @(negedge clk);
      runOp(3'b111, 32'd100, 32'd7, r, lat, st);
      total++; if (r !== 32'd2) begin bad++; $display("FAIL remu: got %h want 00000002", r); end
      @(negedge clk);
      runOp(3'b100, 32'd20, 32'hFFFFFFFA, r, lat, st);
      total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_negdivisor: got %h want fffffffd", r); end
      @(negedge clk);
      runOp(3'b110, 32'd20, 32'hFFFFFFFA, r, lat, st);
      total++; if (r !== 32'd2) begin bad++; $display("FAIL rem_negdivisor: got %h want 00000002", r); end
      @(negedge clk);
      runOp(3'b101, 32'hFFFFFFFF, 32'd1, r, lat, st);
      total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_max: got %h want ffffffff", r); end
      @(negedge clk);
   endtask

   task automatic test_special();
      logic [31:0] r; int lat, st;
      runOp(3'b101, 32'd5, 32'd0, r, lat, st);
      total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero: got %h want ffffffff", r); end
      total++; if (lat !== 1) begin bad++; $display("FAIL divu_zero_latency: got %0d want 1", lat); end
      @(negedge clk);
      runOp(3'b110, 32'd5, 32'd0, r, lat, st);
      total++; if (r !== 32'd5) begin bad++; $display("FAIL rem_zero: got %h want 00000005", r); end
      total++; if (lat !== 1) begin bad++; $display("FAIL rem_zero_latency: got %0d want 1", lat); end
      @(negedge clk);
      runOp(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, st);
      total++; if (r !== 32'h80000000) begin bad++; $display("FAIL div_ovf: got %h want 80000000", r); end
      total++; if (lat !== 1) begin bad++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
      @(negedge clk);
      runOp(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, st);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf: got %h want 00000000", r); end
      @(negedge clk);
      runOp(3'b100, 32'hFFFFFFF9, 32'd0, r, lat, st);
      total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_zero_signed: got %h want ffffffff", r); end
      @(negedge clk);
      runOp(3'b111, 32'h12345678, 32'd0, r, lat, st);
      total++; if (r !== 32'h12345678) begin bad++; $display("FAIL remu_zero: got %h want 12345678", r); end
      @(negedge clk);
   endtask

   task automatic test_kill();
      logic [31:0] r; int lat, st; bit sawDone;
      runOp(3'b000, 32'd3, 32'd5, r, lat, st);
      @(negedge clk);
      funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy: got %b want 0", busy); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL kill_stall: got %b want 0", stall_req); end
      sawDone = 1'b0;
      repeat (40) begin
         if (done) sawDone = 1'b1;
         @(negedge clk);
      end
      total++; if (sawDone !== 1'b0) begin bad++; $display("FAIL kill_no_done: got %b want 0", sawDone); end
      total++; if (result !== 32'd15) begin bad++; $display("FAIL kill_result_kept: got %h want 0000000f", result); end
      // Back-to-back: second start in the IDLE cycle right after DONE
      runOp(3'b000, 32'd6, 32'd9, r, lat, st);
      total++; if (r !== 32'd54) begin bad++; $display("FAIL b2b_first: got %h want 00000036", r); end
      @(negedge clk);
      runOp(3'b111, 32'd100, 32'd7, r, lat, st);
      total++; if (r !== 32'd2) begin bad++; $display("FAIL b2b_second: got %h want 00000002", r); end
      total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency: got %0d want 34", lat); end
      @(negedge clk);
   endtask

   task automatic test_start_kill_same();
      funct3 = 3'b000; op_a = 32'd4; op_b = 32'd4; start = 1'b1; kill = 1'b1;
      #1;
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL startkill_stall: got %b want 0", stall_req); end
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL startkill_busy: got %b want 0", busy); end
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int lat;
      funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      lat = 9;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      total++; if (lat !== 34) begin bad++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
      total++; if (result !== 32'd14) begin bad++; $display("FAIL busy_start_result: got %h want 0000000e", result); end
      // start presented while in DONE must not relatch
      funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_start_busy: got %b want 0", busy); end
      total++; if (result !== 32'd14) begin bad++; $display("FAIL done_start_result: got %h want 0000000e", result); end
      @(negedge clk);
   endtask

   task automatic test_reset_fix();
      logic [31:0] r; int lat, st; bit sawDone;
      funct3 = 3'b000; op_a = 32'd7; op_b = 32'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (32) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL fix_busy: got %b want 1", busy); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfix_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rstfix_done: got %b want 0", done); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rstfix_stall: got %b want 0", stall_req); end
      total++; if (result !== 32'h0) begin bad++; $display("FAIL rstfix_result: got %h want 00000000", result); end
      rst = 1'b1;
      sawDone = 1'b0;
      repeat (5) begin
         if (done) sawDone = 1'b1;
         @(negedge clk);
      end
      total++; if (sawDone !== 1'b0) begin bad++; $display("FAIL rstfix_no_done: got %b want 0", sawDone); end
      runOp(3'b000, 32'd7, 32'd11, r, lat, st);
      total++; if (r !== 32'd77) begin bad++; $display("FAIL after_reset_mul: got %h want 0000004d", r); end
      total++; if (lat !== 34) begin bad++; $display("FAIL after_reset_latency: got %0d want 34", lat); end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      @(negedge clk);
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_start_kill_same();
      test_start_ignored();
      test_reset_fix();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
